// File: rtl/serial_subtractor_fsm.sv
// Bit-serial Mealy subtractor: A - B over WIDTH-bit words, LSB-first, one bit pair per clock.
// The per-bit difference is combinational; the word result, final borrow and status pulses are registered.
module serial_subtractor_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  output logic             diff,
  output logic             diff_valid,
  output logic [WIDTH-1:0] diff_word,
  output logic             borrow,
  output logic             done,
  output logic             aborted,
  output logic             busy
);

  // state | meaning
  // IDLE  | no word in progress
  // NB    | in word, borrow-in 0
  // BR    | in word, borrow-in 1
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NB   = 2'd1;
  localparam logic [1:0] BR   = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] diff_word_q, diff_word_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             accept, bin, diff_bit, bout, last;
  logic [CW-1:0]    cnt_eff;
  logic [WIDTH-1:0] word_nxt;

  always_comb begin
    accept   = valid & (start | (state_q != IDLE));
    // A start bit always begins a fresh word, so it never sees a pending borrow.
    bin      = (state_q == BR) & ~start;
    diff_bit = a ^ b ^ bin;
    bout     = (~a & b) | (~(a ^ b) & bin);
    cnt_eff  = start ? '0 : bit_cnt_q;
    last     = (cnt_eff == LAST_IDX);
    word_nxt = (start ? '0 : shreg_q) | (WIDTH'(diff_bit) << cnt_eff);

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    diff_word_d = diff_word_q;
    borrow_d    = borrow_q;
    done_d      = 1'b0;
    aborted_d   = valid & start & (state_q != IDLE);

    if (accept) begin
      if (last) begin
        state_d     = IDLE;
        bit_cnt_d   = '0;
        shreg_d     = '0;
        diff_word_d = word_nxt;
        borrow_d    = bout;
        done_d      = 1'b1;
      end else begin
        state_d   = bout ? BR : NB;
        bit_cnt_d = cnt_eff + 1'b1;
        shreg_d   = word_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      diff_word_q <= '0;
      borrow_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      diff_word_q <= diff_word_d;
      borrow_q    <= borrow_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign diff       = accept & diff_bit;
  assign diff_valid = accept;
  assign diff_word  = diff_word_q;
  assign borrow     = borrow_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Self-checking bench for serial_subtractor_fsm at WIDTH=4: vector table plus scoreboard of
// completed words, with hand-written stall, abort and reset sequences.
module tb_serial_subtractor_fsm;

  localparam int W = 4;

  logic         clk, rst, valid, start, a, b;
  logic         diff, diff_valid, borrow, done, aborted, busy;
  logic [W-1:0] diff_word;

  serial_subtractor_fsm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .start(start), .a(a), .b(b),
    .diff(diff), .diff_valid(diff_valid), .diff_word(diff_word), .borrow(borrow),
    .done(done), .aborted(aborted), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  typedef struct {
    logic [W-1:0] a_w;
    logic [W-1:0] b_w;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  exp_t sb[$];
  int   done_times[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   abort_cnt = 0;
  int   busy_cnt = 0;
  int   last_done_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff_word", 32'(diff_word), 32'(e.d));
          chk("borrow", 32'(borrow), 32'(e.bo));
        end
        done_cnt++;
        last_done_cyc = cyc;
        done_times.push_back(cyc);
      end
      if (aborted === 1'b1) abort_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic send_bit(input logic v, input logic s, input logic ai, input logic bi,
                          input logic exp_dv, input logic exp_d);
    valid = v; start = s; a = ai; b = bi;
    #2;
    chk("diff_valid", 32'(diff_valid), 32'(exp_dv));
    chk("diff", 32'(diff), 32'(exp_d));
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    send_bit(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] aw, input logic [W-1:0] bw,
                           input logic [W-1:0] d, input logic bo,
                           input int stall_after, input int stall_len, output int st_cyc);
    exp_t e;
    st_cyc = 0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        e.d = d; e.bo = bo;
        sb.push_back(e);
      end
      send_bit(1'b1, i == 0, aw[i], bw[i], 1'b1, d[i]);
      if (i == 0) st_cyc = cyc;
      if (i == stall_after) repeat (stall_len) idle_cycle();
    end
  endtask

  vec_t vecs[7];
  int   st, n0, ab0, dn0;

  initial begin
    vecs[0] = '{4'd5,  4'd3,  4'b0010, 1'b0};
    vecs[1] = '{4'd3,  4'd5,  4'b1110, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  4'b0000, 1'b0};
    vecs[3] = '{4'd0,  4'd1,  4'b1111, 1'b1};
    vecs[4] = '{4'd15, 4'd15, 4'b0000, 1'b0};
    vecs[5] = '{4'd9,  4'd6,  4'b0011, 1'b0};
    vecs[6] = '{4'd6,  4'd9,  4'b1101, 1'b1};

    rst = 1'b1; valid = 1'b0; start = 1'b0; a = 1'b0; b = 1'b0;
    #3;
    chk("rst_diff_word", 32'(diff_word), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff_valid", 32'(diff_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // valid without start in IDLE is ignored
    send_bit(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);
    idle_cycle();

    // basic 5-3 with latency check
    send_word(4'd5, 4'd3, 4'b0010, 1'b0, -1, 0, st);
    idle_cycle();
    chk("latency", 32'(last_done_cyc - st), 32'd3);

    // 3-5 with busy duration
    busy_cnt = 0;
    send_word(4'd3, 4'd5, 4'b1110, 1'b1, -1, 0, st);
    idle_cycle();
    chk("busy_cycles", 32'(busy_cnt), 32'd3);

    // table vectors, back-to-back
    n0 = done_times.size();
    foreach (vecs[k]) send_word(vecs[k].a_w, vecs[k].b_w, vecs[k].d, vecs[k].bo, -1, 0, st);
    idle_cycle();
    chk("b2b_count", 32'(done_times.size() - n0), 32'd7);
    for (int k = n0 + 1; k < done_times.size(); k++)
      chk("b2b_spacing", 32'(done_times[k] - done_times[k-1]), 32'd4);

    // stall of 3 cycles after bit 1
    send_word(4'd5, 4'd3, 4'b0010, 1'b0, 1, 3, st);
    idle_cycle();
    chk("stall_latency", 32'(last_done_cyc - st), 32'd6);

    // abort: two bits of 5-3, then restart with 3-5
    ab0 = abort_cnt; dn0 = done_cnt;
    send_bit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(4'd3, 4'd5, 4'b1110, 1'b1, -1, 0, st);
    idle_cycle();
    chk("abort_pulses", 32'(abort_cnt - ab0), 32'd1);
    chk("abort_dones", 32'(done_cnt - dn0), 32'd1);
    chk("abort_word", 32'(diff_word), 32'hE);
    chk("abort_borrow", 32'(borrow), 32'd1);

    // reset mid-word
    dn0 = done_cnt; ab0 = abort_cnt;
    send_bit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    valid = 1'b0; start = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_aborted", 32'(aborted), 32'd0);
    chk("mid_rst_diff_word", 32'(diff_word), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_word(4'd5, 4'd3, 4'b0010, 1'b0, -1, 0, st);
    idle_cycle();
    idle_cycle();
    chk("post_rst_dones", 32'(done_cnt - dn0), 32'd1);
    chk("post_rst_aborts", 32'(abort_cnt - ab0), 32'd0);
    chk("post_rst_word", 32'(diff_word), 32'h2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_fsm.md
# serial_subtractor_fsm

Bit-serial Mealy-machine subtractor computing A − B over WIDTH-bit words presented LSB-first, one bit pair per clock. It is the inverse-operation companion to the team's Mealy half-adder FSM. It uses the same clk/rst, a/b bit-input style, with a borrow state replacing the carry state. Per-bit difference is combinational (Mealy). The full difference word, final borrow and completion pulse are registered for downstream consumers.

## Interface
- WIDTH, default 8: bits per word; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  a/b carry a bit pair this cycle.
- start  input  1  qualified by valid; marks bit 0 (LSB) of a new word.
- a  input  1  minuend bit.
- b  input  1  subtrahend bit.
- diff  output  1  Mealy difference bit for the current a/b; 0 whenever diff_valid=0.
- diff_valid  output  1  diff is meaningful this cycle (combinational).
- diff_word  output  WIDTH  registered full difference of the last completed word.
- borrow  output  1  registered final borrow of the last completed word (1 ⇔ A < B unsigned).
- done  output  1  one-cycle pulse; diff_word/borrow updated.
- aborted  output  1  one-cycle pulse; an in-progress word was discarded by a new start.
- busy  output  1  FSM is mid-word (state NB or BR).

## Operation
- States:
  - IDLE: no word in progress.
  - NB: in word, borrow-in 0.
  - BR: in word, borrow-in 1.
- Borrow-in bin = 1 only in BR. In IDLE, and on any start bit, bin = 0.
- Accepted bit: valid=1, and either start=1 or state≠IDLE.
- For an accepted bit:
  - diff = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
- diff_valid = accepted bit. With valid=0, or valid=1 & start=0 in IDLE, diff_valid=0, diff=0, and nothing changes.
- bit_cnt counts accepted bits in the current word: 0..WIDTH−1. A start bit is bit 0.
- A shift register collects diff bits LSB-first at position bit_cnt.
- Non-last accepted bit: next state = bout ? BR : NB; bit_cnt increments.
- Last bit (bit_cnt = WIDTH−1):
  - next state IDLE, bit_cnt ← 0.
  - diff_word ← assembled word including this bit.
  - borrow ← bout; done ← 1 for one cycle.
- WIDTH=1: every start bit is also the last bit.
- valid=0 while busy: stall. State, bit_cnt and shift register hold; no timeout.
- Start while busy: the in-progress word is discarded.
  - aborted pulses the following cycle.
  - The bit is processed as bit 0 of a new word with bin=0.
  - diff_word and borrow are not updated; done does not pulse for the discarded word.
- Start on the cycle right after a last bit: state is IDLE, so the start is accepted with no bubble. done for the previous word and diff for the new bit 0 coexist in that cycle.
- diff_word and borrow hold their values until the next done.

## Timing
- Reset, asynchronous, effective immediately:
  - state IDLE, bit_cnt 0, shift register 0.
  - diff_word 0, borrow 0, done 0, aborted 0, busy 0.
  - diff 0 and diff_valid 0, since state is IDLE and no start is asserted.
- Reset mid-word discards the word with no done and no aborted pulse.
- diff/diff_valid: zero latency, combinational from a, b, valid, start and state.
- done, aborted, diff_word, borrow, busy: registered. Visible the cycle after the clock edge that sampled the triggering bit.
- Word latency: done asserts 1 cycle after the last bit's sampling edge, i.e. WIDTH cycles after the start edge when there are no stalls.
- Throughput: one word per WIDTH cycles, back-to-back.
- busy = (state ≠ IDLE). It rises after the start edge and falls after the last-bit edge. With WIDTH=1, busy stays 0.

## Test plan
- Basic, WIDTH=4, 5−3, no stalls.
  - Stimulus: a=1,0,1,0 and b=1,1,0,0 LSB-first, start on bit 0.
  - Required: diff=0,1,0,0; then done=1, diff_word=4'b0010, borrow=0.
- Negative result, 3−5.
  - Stimulus: a=1,1,0,0 and b=1,0,1,0.
  - Required: diff=0,1,1,1; diff_word=4'b1110, borrow=1; busy high for exactly 3 cycles.
- Boundaries.
  - 0−0 → diff_word=0, borrow=0.
  - 0−1 → diff_word=4'b1111, borrow=1.
  - 15−15 → diff_word=0, borrow=0.
  - Run back-to-back; each done is exactly 4 cycles apart.
- Stall.
  - Stimulus: 5−3 with valid=0 for 3 cycles after bit 1.
  - Required: diff_valid=0 during the stall; result identical to the no-stall case; done delayed by 3 cycles.
- Abort.
  - Stimulus: start a word, send 2 bits, then assert start with 3−5.
  - Required: aborted pulses once; no done for the first word; final diff_word=4'b1110, borrow=1.
- Reset mid-word.
  - Stimulus: assert rst between clock edges after 2 bits.
  - Required: busy, done and aborted are 0 immediately and diff_word=0. The next 5−3 word gives 4'b0010.
  - Additional check: valid=1 with start=0 in IDLE → diff_valid=0, no state change.
